// File: rtl/psg_ctrl_if.sv
// Bus bundle between the PSG front-end controller and its neighbours:
// the CPU register path, the envelope engine, and the psg attribute/sample port.
`timescale 1ns/1ps
interface psg_ctrl_if;
   logic       psg_en;
   logic       cpu_write;
   logic [5:0] cpu_addr;
   logic [7:0] cpu_wrdata;
   logic       cpu_full;
   logic       cpu_ovf;
   logic       ovf_clr;
   logic       env_req;
   logic [5:0] env_addr;
   logic [7:0] env_wrdata;
   logic       env_ack;
   logic       attr_write;
   logic [5:0] attr_addr;
   logic [7:0] attr_wrdata;
   logic       next_sample;
   logic [7:0] tick_count;

   modport slave (
      input  psg_en, cpu_write, cpu_addr, cpu_wrdata, ovf_clr,
             env_req, env_addr, env_wrdata,
      output cpu_full, cpu_ovf, env_ack, attr_write, attr_addr, attr_wrdata,
             next_sample, tick_count
   );

   modport master (
      output psg_en, cpu_write, cpu_addr, cpu_wrdata, ovf_clr,
             env_req, env_addr, env_wrdata,
      input  cpu_full, cpu_ovf, env_ack, attr_write, attr_addr, attr_wrdata,
             next_sample, tick_count
   );
endinterface

// File: rtl/psg_ctrl.sv
// PSG front-end: sample-strobe divider plus a CPU-FIFO / envelope arbiter
// sharing the single attribute-RAM write port.
`timescale 1ns/1ps
module psg_ctrl #(
   parameter int SAMPLE_DIV = 512,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   psg_ctrl_if.slave  bus
);
   localparam int               DIV_W     = $clog2(SAMPLE_DIV);
   localparam int               AW        = $clog2(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [AW:0]      CNT_FULL  = (AW+1)'(FIFO_DEPTH);

   logic [13:0]      r_fifo [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_cpu_full;
   logic             r_cpu_ovf;
   logic             r_last_env;
   logic             r_env_ack;
   logic             r_attr_write;
   logic [5:0]       r_attr_addr;
   logic [7:0]       r_attr_wrdata;
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_next_sample;
   logic [7:0]       r_tick_count;

   logic             w_cpu_pend;
   logic             w_env_pend;
   logic             w_grant_cpu;
   logic             w_grant_env;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [AW:0]      w_count_nxt;
   logic [13:0]      w_head;

   // Arbitration and FIFO push/pop decisions for this cycle
   always_comb begin
      w_cpu_pend  = (r_count != (AW+1)'(0));
      // The ack cycle is masked so a still-held request is not issued twice
      w_env_pend  = bus.env_req & ~r_env_ack;
      w_grant_cpu = w_cpu_pend & (~w_env_pend | r_last_env);
      w_grant_env = w_env_pend & (~w_cpu_pend | ~r_last_env);
      w_pop       = w_grant_cpu;
      w_push      = bus.cpu_write & ((r_count != CNT_FULL) | w_pop);
      w_drop      = bus.cpu_write & ~w_push;
      w_head      = r_fifo[r_rd_ptr];
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // FIFO storage; contents are don't-care while the count says empty
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= {bus.cpu_addr, bus.cpu_wrdata};
      end
   end

   // Control state, registered outputs and sample divider
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_cpu_full    <= 1'b0;
         r_cpu_ovf     <= 1'b0;
         r_last_env    <= 1'b1;
         r_env_ack     <= 1'b0;
         r_attr_write  <= 1'b0;
         r_attr_addr   <= 6'd0;
         r_attr_wrdata <= 8'd0;
         r_div_cnt     <= '0;
         r_next_sample <= 1'b0;
         r_tick_count  <= 8'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count    <= w_count_nxt;
         r_cpu_full <= (w_count_nxt == CNT_FULL);
         // A drop in the same cycle as a clear leaves the flag set
         if (w_drop)           r_cpu_ovf <= 1'b1;
         else if (bus.ovf_clr) r_cpu_ovf <= 1'b0;

         r_attr_write <= w_grant_cpu | w_grant_env;
         r_env_ack    <= w_grant_env;
         if (w_grant_cpu) begin
            {r_attr_addr, r_attr_wrdata} <= w_head;
            r_last_env <= 1'b0;
         end else if (w_grant_env) begin
            r_attr_addr   <= bus.env_addr;
            r_attr_wrdata <= bus.env_wrdata;
            r_last_env    <= 1'b1;
         end

         if (!bus.psg_en) begin
            r_div_cnt     <= '0;
            r_next_sample <= 1'b0;
         end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt     <= '0;
            r_next_sample <= 1'b1;
            r_tick_count  <= r_tick_count + 8'd1;
         end else begin
            r_div_cnt     <= r_div_cnt + DIV_W'(1);
            r_next_sample <= 1'b0;
         end
      end
   end

   assign bus.cpu_full    = r_cpu_full;
   assign bus.cpu_ovf     = r_cpu_ovf;
   assign bus.env_ack     = r_env_ack;
   assign bus.attr_write  = r_attr_write;
   assign bus.attr_addr   = r_attr_addr;
   assign bus.attr_wrdata = r_attr_wrdata;
   assign bus.next_sample = r_next_sample;
   assign bus.tick_count  = r_tick_count;
endmodule

// File: tb/tb_psg_ctrl.sv
// Directed bench for psg_ctrl: divider timing, CPU/env arbitration order via a
// scoreboard queue, FIFO overflow and mid-operation reset.
`timescale 1ns/1ps
module tb_psg_ctrl;
   typedef struct packed {
      logic       is_env;
      logic [5:0] addr;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_ack    = 0;
   exp_t q[$];

   psg_ctrl_if bus();

   psg_ctrl #(.SAMPLE_DIV(512), .FIFO_DEPTH(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic is_env, input logic [5:0] a, input logic [7:0] d);
      exp_t e;
      e.is_env = is_env;
      e.addr   = a;
      e.data   = d;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.psg_en     = 1'b0;
      bus.cpu_write  = 1'b0;
      bus.cpu_addr   = 6'd0;
      bus.cpu_wrdata = 8'd0;
      bus.ovf_clr    = 1'b0;
      bus.env_req    = 1'b0;
      bus.env_addr   = 6'd0;
      bus.env_wrdata = 8'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      for (int c = 0; c < bound; c++) begin
         if (q.size() == 0) break;
         tick();
      end
      check("sb_drained", 32'(q.size()), 32'd0);
   endtask

   // Scoreboard monitor: every attr_write must match the next expected entry
   always @(negedge clk) begin
      exp_t e;
      if (bus.env_ack) begin
         n_ack++;
         check("ack_with_write", 32'(bus.attr_write), 32'd1);
      end
      if (bus.attr_write) begin
         check("sb_pending", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("attr_addr", 32'(bus.attr_addr), 32'(e.addr));
            check("attr_wrdata", 32'(bus.attr_wrdata), 32'(e.data));
            check("env_ack_match", 32'(bus.env_ack), 32'(e.is_env));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses[$];
      int found;
      int ack0;

      // ---- reset state ----
      do_reset();
      check("rst_attr_write", 32'(bus.attr_write), 32'd0);
      check("rst_env_ack", 32'(bus.env_ack), 32'd0);
      check("rst_cpu_full", 32'(bus.cpu_full), 32'd0);
      check("rst_cpu_ovf", 32'(bus.cpu_ovf), 32'd0);
      check("rst_next_sample", 32'(bus.next_sample), 32'd0);
      check("rst_tick_count", 32'(bus.tick_count), 32'd0);

      // ---- divider: 2048 cycles -> 4 pulses, 512 apart ----
      bus.psg_en = 1'b1;
      for (int c = 1; c <= 2048; c++) begin
         tick();
         if (bus.next_sample) pulses.push_back(c);
      end
      check("pulse_count", 32'(pulses.size()), 32'd4);
      if (pulses.size() == 4) begin
         check("first_pulse", 32'(pulses[0]), 32'd512);
         for (int k = 1; k < 4; k++) check("pulse_gap", 32'(pulses[k] - pulses[k-1]), 32'd512);
      end
      check("tick_count_4", 32'(bus.tick_count), 32'd4);

      // ---- divider: disable at div_cnt=100 for 10 cycles ----
      repeat (100) tick();
      bus.psg_en = 1'b0;
      found = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.next_sample) found++;
      end
      check("no_pulse_disabled", 32'(found), 32'd0);
      check("tick_hold", 32'(bus.tick_count), 32'd4);
      bus.psg_en = 1'b1;
      found = 0;
      for (int c = 1; c <= 600; c++) begin
         tick();
         if (bus.next_sample) begin
            found = c;
            break;
         end
      end
      check("reenable_latency", 32'(found), 32'd512);
      check("tick_count_5", 32'(bus.tick_count), 32'd5);
      bus.psg_en = 1'b0;

      // ---- CPU write, idle arbiter: two cycles of latency ----
      do_reset();
      bus.cpu_write  = 1'b1;
      bus.cpu_addr   = 6'h05;
      bus.cpu_wrdata = 8'hA5;
      q.push_back(mk(1'b0, 6'h05, 8'hA5));
      tick();
      bus.cpu_write = 1'b0;
      check("cpu_lat_n1", 32'(bus.attr_write), 32'd0);
      tick();
      check("cpu_lat_n2", 32'(bus.attr_write), 32'd1);
      check("cpu_lat_addr", 32'(bus.attr_addr), 32'h05);
      check("cpu_lat_data", 32'(bus.attr_wrdata), 32'hA5);
      tick();
      check("cpu_lat_single", 32'(bus.attr_write), 32'd0);
      wait_drain(4);

      // ---- contention: CPU0, ENV, CPU1, CPU2, CPU3 ----
      do_reset();
      ack0 = n_ack;
      bus.env_addr   = 6'h3E;
      bus.env_wrdata = 8'h11;
      q.push_back(mk(1'b0, 6'h01, 8'h10));
      q.push_back(mk(1'b1, 6'h3E, 8'h11));
      q.push_back(mk(1'b0, 6'h02, 8'h20));
      q.push_back(mk(1'b0, 6'h03, 8'h30));
      q.push_back(mk(1'b0, 6'h04, 8'h40));
      bus.cpu_write = 1'b1; bus.cpu_addr = 6'h01; bus.cpu_wrdata = 8'h10;
      tick();
      bus.cpu_addr = 6'h02; bus.cpu_wrdata = 8'h20; bus.env_req = 1'b1;
      tick();
      bus.cpu_addr = 6'h03; bus.cpu_wrdata = 8'h30;
      tick();
      check("env_ack_seen", 32'(bus.env_ack), 32'd1);
      bus.env_req  = 1'b0;
      bus.cpu_addr = 6'h04; bus.cpu_wrdata = 8'h40;
      tick();
      bus.cpu_write = 1'b0;
      wait_drain(10);
      check("env_ack_single", 32'(n_ack - ack0), 32'd1);

      // ---- overflow: env held continuously, CPU writes every cycle ----
      do_reset();
      bus.env_addr   = 6'h3E;
      bus.env_wrdata = 8'h22;
      for (int i = 0; i < 4; i++) begin
         q.push_back(mk(1'b1, 6'h3E, 8'h22));
         q.push_back(mk(1'b0, 6'(i), 8'(8'h80 + i)));
      end
      q.push_back(mk(1'b1, 6'h3E, 8'h22));
      for (int i = 4; i < 8; i++) q.push_back(mk(1'b0, 6'(i), 8'(8'h80 + i)));
      for (int i = 0; i < 9; i++) begin
         bus.cpu_write  = 1'b1;
         bus.cpu_addr   = 6'(i);
         bus.cpu_wrdata = 8'(8'h80 + i);
         bus.env_req    = 1'b1;
         tick();
         check("ovf_cpu_full", 32'(bus.cpu_full), 32'(i >= 6));
         check("ovf_cpu_ovf", 32'(bus.cpu_ovf), 32'(i == 8));
      end
      bus.cpu_write = 1'b0;
      bus.env_req   = 1'b0;
      bus.ovf_clr   = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("ovf_cleared", 32'(bus.cpu_ovf), 32'd0);
      check("full_after_pop", 32'(bus.cpu_full), 32'd0);
      wait_drain(10);

      // ---- reset with 3 FIFO entries and env_req high ----
      do_reset();
      bus.env_addr   = 6'h3E;
      bus.env_wrdata = 8'h33;
      q.push_back(mk(1'b1, 6'h3E, 8'h33));
      q.push_back(mk(1'b0, 6'h10, 8'h50));
      q.push_back(mk(1'b1, 6'h3E, 8'h33));
      q.push_back(mk(1'b0, 6'h11, 8'h51));
      q.push_back(mk(1'b1, 6'h3E, 8'h33));
      for (int i = 0; i < 5; i++) begin
         bus.cpu_write  = 1'b1;
         bus.cpu_addr   = 6'(6'h10 + i);
         bus.cpu_wrdata = 8'(8'h50 + i);
         bus.env_req    = 1'b1;
         tick();
      end
      bus.cpu_write = 1'b0;
      rst = 1'b1;
      tick();
      check("mid_rst_attr_write", 32'(bus.attr_write), 32'd0);
      check("mid_rst_env_ack", 32'(bus.env_ack), 32'd0);
      check("mid_rst_cpu_full", 32'(bus.cpu_full), 32'd0);
      check("mid_rst_attr_addr", 32'(bus.attr_addr), 32'd0);
      check("mid_rst_attr_wrdata", 32'(bus.attr_wrdata), 32'd0);
      check("mid_rst_tick_count", 32'(bus.tick_count), 32'd0);
      rst         = 1'b0;
      bus.env_req = 1'b0;
      found = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.attr_write) found++;
      end
      check("fifo_discarded", 32'(found), 32'd0);
      check("sb_empty_end", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
